// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The ovf signal is present only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         c;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, s, c, ovf
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, s, c, ovf
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, s, c
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, s, c
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder built from two cascaded half-adder stages and a carry flop.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow flag (ovf).
module serial_adder #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_sh_q, a_sh_d;
  logic [W-1:0]   b_sh_q, b_sh_d;
  logic [W-2:0]   sum_q, sum_d;
  logic           cy_q, cy_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   s_q, s_d;
  logic           c_q, c_d;
`ifdef SERIAL_ADD_OVF_EN
  logic           a_msb_q, a_msb_d;
  logic           b_msb_q, b_msb_d;
  logic           ovf_q, ovf_d;
`endif

  logic           h1, c1, sb, c2, cy_next;
  logic [W-1:0]   sum_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
`ifdef SERIAL_ADD_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_d     = c_q;
`ifdef SERIAL_ADD_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    h1      = a_sh_q[0] ^ b_sh_q[0];
    c1      = a_sh_q[0] & b_sh_q[0];
    sb      = h1 ^ cy_q;
    c2      = h1 & cy_q;
    cy_next = c1 | c2;
    // Only W-1 collected bits are stored; the current bit completes the word.
    sum_next = {sb, sum_q};

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          sum_d   = '0;
          cy_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
          a_msb_d = bus.a[W-1];
          b_msb_d = bus.b[W-1];
`endif
          state_d = ADD;
        end
      end
      ADD: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        sum_d  = sum_next[W-1:1];
        cy_d   = cy_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          s_d     = sum_next;
          c_d     = cy_next;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = (a_msb_q == b_msb_q) & (sum_next[W-1] != a_msb_q);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // State already reads IDLE during reset, so gate ready with rst directly.
    bus.in_ready  = (state_q == IDLE) && !rst;
    bus.out_valid = (state_q == DONE);
    bus.s         = s_q;
    bus.c         = c_q;
`ifdef SERIAL_ADD_OVF_EN
    bus.ovf       = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (W=8); ovf cases run when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  logic prev_ov  = 1'b0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];

  serial_adder_if #(.W(W)) bus();

  serial_adder #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t       e;
    logic [W:0] t;
    t     = {1'b0, a} + {1'b0, b};
    e.s   = t[W-1:0];
    e.c   = t[W];
    e.ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  // Push on accepted operands, pop and compare on the output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.a, bus.b));
        last_acc = cyc + 1;
        acc_q.push_back(cyc + 1);
      end
      if (bus.out_valid && !prev_ov)
        check("latency", cyc - last_acc, W);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 0, 1);
        end else begin
          e = sb.pop_front();
          check("s", bus.s, e.s);
          check("c", bus.c, e.c);
`ifdef SERIAL_ADD_OVF_EN
          check("ovf", bus.ovf, e.ovf);
`endif
        end
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic wait_accept();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.in_ready) seen = 1;
    end
    if (!seen) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    if (!seen) check("valid_timeout", 0, 1);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    wait_accept();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    wait_valid();
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_s", bus.s, 0);
    check("rst_c", bus.c, 0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", bus.ovf, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    send(8'h0F, 8'h01); drain();
    send(8'hFF, 8'h01); drain();

    // Backpressure: result held while a new pair waits unconsumed
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(8'h3C, 8'h0F);
    wait_valid();
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a        = 8'h01;
    bus.b        = 8'h01;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_s", bus.s, 8'h4B);
      check("bp_c", bus.c, 0);
      check("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();

    // Reset during ADD at bit 3
    send(8'hAA, 8'h55);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_s", bus.s, 0);
    check("mid_rst_c", bus.c, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rel_in_ready", bus.in_ready, 1);
    send(8'h12, 8'h34); drain();

    // Back-to-back with in_valid and out_ready held high
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a        = 8'h01;
    bus.b        = 8'h02;
    wait_accept();
    @(posedge clk); #1;
    bus.a = 8'h80;
    bus.b = 8'h80;
    wait_accept();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (acc_q.size() >= 2)
      check("b2b_spacing", acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2], W + 2);
    else
      check("b2b_accepts", acc_q.size(), 2);
    drain();

`ifdef SERIAL_ADD_OVF_EN
    send(8'h7F, 8'h01); drain();
    send(8'h80, 8'h80); drain();
    send(8'hFF, 8'h01); drain();
`endif

    repeat (2) @(posedge clk);
    check("sb_left", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
